// File: rtl/decoder_pkg.sv
// Shared br32 definitions: field positions, opcodes, encoder request and error types.
package decoder_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned OPC_W      = 6;
   localparam int unsigned COND_W     = 3;
   localparam int unsigned KIND_W     = 3;
   localparam int unsigned IMM16_W    = 16;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned ERR_W      = 2;

   localparam int unsigned RD_LSB     = 6;
   localparam int unsigned RS1_LSB    = 11;
   localparam int unsigned RS2_LSB    = 16;
   localparam int unsigned IMM_LSB    = 16;
   localparam int unsigned FUNCT_LSB  = 21;
   localparam int unsigned BR_OFF_LSB = 6;

   localparam logic [5:0] OP_ALU_RR    = 6'h3E;
   localparam logic [5:0] OP_ADR       = 6'h34;
   localparam logic [1:0] CLASS_ALU_RI = 2'd1;
   localparam logic [1:0] CLASS_MEM    = 2'd2;
   localparam logic [2:0] CLASS_BR     = 3'b001;

   localparam logic [2:0] ALU_OR       = 3'd2;

   typedef enum logic [KIND_W-1:0] {
      K_ALU_RR = 3'd0,
      K_ALU_RI = 3'd1,
      K_LI     = 3'd2,
      K_MEM    = 3'd3,
      K_ADR    = 3'd4,
      K_BR     = 3'd5
   } enc_kind_t;

   typedef enum logic [ERR_W-1:0] {
      E_NONE    = 2'd0,
      E_RANGE   = 2'd1,
      E_ALIGN   = 2'd2,
      E_ILLEGAL = 2'd3
   } enc_err_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SECOND = 2'd2
   } enc_state_t;

   typedef struct packed {
      enc_kind_t            kind;
      logic [REG_W-1:0]     rd;
      logic [REG_W-1:0]     rs1;
      logic [REG_W-1:0]     rs2;
      logic [OPC_W-1:0]     opc;
      logic [COND_W-1:0]    cond;
      logic [INSTR_W-1:0]   imm;
   } enc_req_t;

   // True when a 32-bit value is representable as a signed 16-bit immediate.
   function automatic logic fits_s16(input logic [INSTR_W-1:0] v);
      return (v[INSTR_W-1:15] == '0) || (v[INSTR_W-1:15] == '1);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational br32 word builder: one request plus word index -> word, word count, error.
module instr_pack
   import decoder_pkg::*;
(
   input  enc_req_t             req,
   input  logic                 idx,
   output logic [INSTR_W-1:0]   word,
   output logic [1:0]           nwords,
   output logic                 err,
   output enc_err_t             code
);

   logic                 hi_zero;
   logic                 lo_zero;
   logic [IMM16_W-1:0]   imm_hi;
   logic [IMM16_W-1:0]   imm_lo;

   assign imm_hi  = req.imm[INSTR_W-1:IMM16_W];
   assign imm_lo  = req.imm[IMM16_W-1:0];
   assign hi_zero = (imm_hi == '0);
   assign lo_zero = (imm_lo == '0);
   assign err     = (code != E_NONE);

   // Encode the selected word and classify errors; illegal beats alignment beats range.
   always_comb begin
      word   = '0;
      nwords = 2'd1;
      code   = E_NONE;
      case (req.kind)
         K_ALU_RR: begin
            word[5:0]                 = OP_ALU_RR;
            word[RD_LSB +: REG_W]     = req.rd;
            word[RS1_LSB +: REG_W]    = req.rs1;
            word[RS2_LSB +: REG_W]    = req.rs2;
            word[FUNCT_LSB +: OPC_W]  = req.opc;
         end
         K_ALU_RI: begin
            word[5:4]                 = CLASS_ALU_RI;
            word[3]                   = req.opc[3];
            word[2:0]                 = req.opc[2:0];
            word[RD_LSB +: REG_W]     = req.rd;
            word[RS1_LSB +: REG_W]    = req.rs1;
            word[IMM_LSB +: IMM16_W]  = imm_lo;
            if (!hi_zero) code = E_RANGE;
         end
         K_LI: begin
            // r0-based OR; a full 32-bit constant becomes high word then rd|low.
            word[5:4]                 = CLASS_ALU_RI;
            word[2:0]                 = ALU_OR;
            word[RD_LSB +: REG_W]     = req.rd;
            if (hi_zero) begin
               word[IMM_LSB +: IMM16_W] = imm_lo;
            end else if (lo_zero) begin
               word[3]                  = 1'b1;
               word[IMM_LSB +: IMM16_W] = imm_hi;
            end else begin
               nwords = 2'd2;
               if (!idx) begin
                  word[3]                  = 1'b1;
                  word[IMM_LSB +: IMM16_W] = imm_hi;
               end else begin
                  word[RS1_LSB +: REG_W]   = req.rd;
                  word[IMM_LSB +: IMM16_W] = imm_lo;
               end
            end
         end
         K_MEM: begin
            word[5:4]                 = CLASS_MEM;
            word[3:2]                 = req.opc[1:0];
            word[1]                   = req.opc[2];
            word[0]                   = req.opc[3];
            word[RD_LSB +: REG_W]     = req.rd;
            word[RS1_LSB +: REG_W]    = req.rs1;
            word[IMM_LSB +: IMM16_W]  = imm_lo;
            if (req.opc[2] && req.opc[3]) code = E_ILLEGAL;
            else if (!fits_s16(req.imm))  code = E_RANGE;
         end
         K_ADR: begin
            word[5:0]                 = OP_ADR;
            word[RD_LSB +: REG_W]     = req.rd;
            word[IMM_LSB +: IMM16_W]  = imm_lo;
            if (!fits_s16(req.imm)) code = E_RANGE;
         end
         K_BR: begin
            word[5:3]                       = CLASS_BR;
            word[2:0]                       = req.cond;
            word[INSTR_W-1:BR_OFF_LSB]      = req.imm[27:2];
            if (req.imm[1:0] != 2'b00)                     code = E_ALIGN;
            else if (req.imm[31:28] != {4{req.imm[27]}})   code = E_RANGE;
         end
         default: begin
            code = E_ILLEGAL;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// br32 instruction encoder: request handshake in, registered word stream and error strobe out.
module instr_encoder
   import decoder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [KIND_W-1:0]    req_kind,
   input  logic [REG_W-1:0]     req_rd,
   input  logic [REG_W-1:0]     req_rs1,
   input  logic [REG_W-1:0]     req_rs2,
   input  logic [OPC_W-1:0]     req_opc,
   input  logic [COND_W-1:0]    req_cond,
   input  logic [INSTR_W-1:0]   req_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_W-1:0]   out_instr,
   output logic                 out_last,
   output logic                 err_valid,
   output logic [ERR_W-1:0]     err_code,
   output logic [CNT_W-1:0]     word_count
);

   enc_state_t            state, state_d;
   enc_req_t              live_req, held_req, held_req_d, pack_req;
   logic                  pack_idx;
   logic [INSTR_W-1:0]    pack_word;
   logic [1:0]            pack_nwords;
   logic                  pack_err;
   enc_err_t              pack_code;

   logic                  out_valid_d;
   logic [INSTR_W-1:0]    out_instr_d;
   logic                  out_last_d;
   logic                  err_valid_d;
   logic [ERR_W-1:0]      err_code_d;
   logic [CNT_W-1:0]      word_count_d;

   logic                  fire;
   logic                  accept;

   assign live_req = '{kind: enc_kind_t'(req_kind), rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                       opc: req_opc, cond: req_cond, imm: req_imm};

   // The second K_LI word is rebuilt from the captured request.
   assign pack_idx = (state == SECOND);
   assign pack_req = pack_idx ? held_req : live_req;

   assign fire      = out_valid && out_ready;
   assign req_ready = (state != SECOND) && (!out_valid || out_ready);
   assign accept    = req_valid && req_ready;

   instr_pack u_pack (
      .req    (pack_req),
      .idx    (pack_idx),
      .word   (pack_word),
      .nwords (pack_nwords),
      .err    (pack_err),
      .code   (pack_code)
   );

   // State, captured request and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         held_req   <= '0;
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_last   <= 1'b0;
         err_valid  <= 1'b0;
         err_code   <= '0;
         word_count <= '0;
      end else begin
         state      <= state_d;
         held_req   <= held_req_d;
         out_valid  <= out_valid_d;
         out_instr  <= out_instr_d;
         out_last   <= out_last_d;
         err_valid  <= err_valid_d;
         err_code   <= err_code_d;
         word_count <= word_count_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state;
      held_req_d   = held_req;
      out_valid_d  = out_valid;
      out_instr_d  = out_instr;
      out_last_d   = out_last;
      err_valid_d  = 1'b0;
      err_code_d   = err_code;
      word_count_d = word_count + CNT_W'(fire);
      case (state)
         SECOND: begin
            if (fire) begin
               out_instr_d = pack_word;
               out_last_d  = 1'b1;
               state_d     = HOLD;
            end
         end
         default: begin
            if (accept) begin
               if (pack_err) begin
                  err_valid_d = 1'b1;
                  err_code_d  = pack_code;
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end else begin
                  out_valid_d = 1'b1;
                  out_instr_d = pack_word;
                  out_last_d  = (pack_nwords == 2'd1);
                  held_req_d  = live_req;
                  state_d     = (pack_nwords == 2'd2) ? SECOND : HOLD;
               end
            end else if (fire) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan steps plus randomized requests.
module tb_instr_encoder;
   import decoder_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready;
   logic [2:0]    req_kind;
   logic [4:0]    req_rd, req_rs1, req_rs2;
   logic [5:0]    req_opc;
   logic [2:0]    req_cond;
   logic [31:0]   req_imm;
   logic          out_valid, out_ready, out_last, err_valid;
   logic [31:0]   out_instr;
   logic [1:0]    err_code;
   logic [15:0]   word_count;

   int            n_cmp = 0;
   int            n_err = 0;
   int            n_fire = 0;
   int            cyc = 0;
   bit            rand_ready = 0;
   bit            stalled = 0;
   logic [32:0]   held_word = '0;
   logic [32:0]   exp_w[$];
   logic [1:0]    exp_e[$];

   instr_encoder dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_opc(req_opc), .req_cond(req_cond), .req_imm(req_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_last(out_last),
      .err_valid(err_valid), .err_code(err_code), .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // Reference: word for the register-immediate format, built arithmetically.
   function automatic logic [31:0] ri_word(longint rd, longint rs1, longint hi, longint op, longint imm16);
      return 32'(16 + hi * 8 + op + rd * 64 + rs1 * 2048 + imm16 * 65536);
   endfunction

   // Reference: expected word list or error code for one request.
   function automatic void model(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [5:0] opc, input logic [2:0] cond,
                                 input logic [31:0] imm);
      logic [31:0] w[$];
      int          code;
      longint      u, s, lo, hi, lrd, lrs1, lrs2, lopc;
      bit          fit16, store, sx;
      code  = 0;
      u     = longint'(imm);
      s     = longint'($signed(imm));
      lo    = u % 65536;
      hi    = u / 65536;
      lrd   = longint'(rd);
      lrs1  = longint'(rs1);
      lrs2  = longint'(rs2);
      lopc  = longint'(opc);
      fit16 = (s >= -32768) && (s <= 32767);
      store = opc[2];
      sx    = opc[3];
      case (k)
         3'd0: w.push_back(32'(62 + lrd * 64 + lrs1 * 2048 + lrs2 * 65536 + lopc * 2097152));
         3'd1: begin
            if (hi != 0) code = 1;
            else w.push_back(ri_word(lrd, lrs1, longint'(opc[3]), longint'(opc[2:0]), lo));
         end
         3'd2: begin
            if (hi == 0) w.push_back(ri_word(lrd, 0, 0, longint'(ALU_OR), lo));
            else if (lo == 0) w.push_back(ri_word(lrd, 0, 1, longint'(ALU_OR), hi));
            else begin
               w.push_back(ri_word(lrd, 0, 1, longint'(ALU_OR), hi));
               w.push_back(ri_word(lrd, lrd, 0, longint'(ALU_OR), lo));
            end
         end
         3'd3: begin
            if (store && sx) code = 3;
            else if (!fit16) code = 1;
            else w.push_back(32'(32 + longint'(opc[1:0]) * 4 + longint'(store) * 2 + longint'(sx)
                                 + lrd * 64 + lrs1 * 2048 + lo * 65536));
         end
         3'd4: begin
            if (!fit16) code = 1;
            else w.push_back(32'(52 + lrd * 64 + lo * 65536));
         end
         3'd5: begin
            if (u % 4 != 0) code = 2;
            else if (s < -134217728 || s > 134217727) code = 1;
            else w.push_back(32'(8 + longint'(cond) + ((s / 4) & 64'h3FFFFFF) * 64));
         end
         default: code = 3;
      endcase
      if (code != 0) exp_e.push_back(2'(code));
      else for (int i = 0; i < w.size(); i++) exp_w.push_back({(i == w.size() - 1), w[i]});
   endfunction

   // Monitor: every handshaken word and error strobe must match the model, in order.
   always @(posedge clk) begin
      if (!rst_n) begin
         stalled = 0;
         n_fire  = 0;
      end else begin
         if (stalled) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_word", 64'({out_last, out_instr}), 64'(held_word));
         end
         if (out_valid && out_ready) begin
            n_fire++;
            check("word_expected", 64'(exp_w.size() != 0), 64'(1));
            if (exp_w.size() != 0) check("word", 64'({out_last, out_instr}), 64'(exp_w.pop_front()));
         end
         stalled   = out_valid && !out_ready;
         held_word = {out_last, out_instr};
         if (err_valid) begin
            check("err_expected", 64'(exp_e.size() != 0), 64'(1));
            if (exp_e.size() != 0) check("err_code_stream", 64'(err_code), 64'(exp_e.pop_front()));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) tick();
   endtask

   // Present one request, wait (bounded) for acceptance, return on the following negedge.
   task automatic do_req(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [5:0] opc, input logic [2:0] cond,
                         input logic [31:0] imm);
      bit ok;
      ok        = 0;
      req_kind  = k;   req_rd  = rd;  req_rs1  = rs1; req_rs2 = rs2;
      req_opc   = opc; req_cond = cond; req_imm = imm;
      req_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         #1;
         if (req_ready) begin
            ok = 1;
            model(k, rd, rs1, rs2, opc, cond, imm);
         end
         tick();
      end
      if (!ok) check("req_accept_timeout", 64'(ok), 64'(1));
   endtask

   task automatic expect_out(input string tag, input logic [31:0] instr, input logic last);
      check({tag, "_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_instr"}, 64'(out_instr), 64'(instr));
      check({tag, "_last"},  64'(out_last),  64'(last));
   endtask

   task automatic expect_err(input string tag, input logic [1:0] code);
      check({tag, "_strobe"}, 64'(err_valid), 64'(1));
      check({tag, "_code"},   64'(err_code),  64'(code));
      check({tag, "_noword"}, 64'(out_valid), 64'(0));
   endtask

   task automatic expect_reset(input string tag);
      check({tag, "_out_valid"},  64'(out_valid),  64'(0));
      check({tag, "_out_instr"},  64'(out_instr),  64'(0));
      check({tag, "_out_last"},   64'(out_last),   64'(0));
      check({tag, "_err_valid"},  64'(err_valid),  64'(0));
      check({tag, "_err_code"},   64'(err_code),   64'(0));
      check({tag, "_word_count"}, 64'(word_count), 64'(0));
      check({tag, "_req_ready"},  64'(req_ready),  64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] wc0;
      int          c0;
      logic [31:0] bnd [8];
      logic [31:0] imm, tmp;
      bnd = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
              32'h0800_0000, 32'hF7FF_FFFC, 32'h0000_0000, 32'hFFFF_0000};

      req_valid = 1'b0; req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
      req_opc = '0; req_cond = '0; req_imm = '0; out_ready = 1'b1;

      // Reset values.
      @(negedge clk);
      expect_reset("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // ALU register-register, one-cycle latency.
      do_req(K_ALU_RR, 5'd3, 5'd4, 5'd5, 6'h12, 3'd0, 32'h0);
      expect_out("alu_rr", 32'h024520FE, 1'b1);
      idle(2);

      // Two-word constant load with a 3-cycle downstream stall.
      out_ready = 1'b0;
      wc0 = word_count;
      do_req(K_LI, 5'd1, 5'd0, 5'd0, 6'd0, 3'd0, 32'h12345678);
      req_valid = 1'b0;
      repeat (3) begin
         expect_out("li_w0", 32'h12340058 | 32'(ALU_OR), 1'b0);
         check("li_req_ready", 64'(req_ready), 64'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      expect_out("li_w1", 32'h56780850 | 32'(ALU_OR), 1'b1);
      tick();
      check("li_word_count", 64'(16'(word_count - wc0)), 64'(2));
      check("li_drained", 64'(out_valid), 64'(0));

      // Branches, including a misaligned offset.
      do_req(K_BR, 5'd0, 5'd0, 5'd0, 6'd0, 3'd2, 32'hFFFF_FFF8);
      expect_out("br_neg", 32'hFFFFFF8A, 1'b1);
      do_req(K_BR, 5'd0, 5'd0, 5'd0, 6'd0, 3'd7, 32'h0000_0100);
      expect_out("br_call", 32'h0000100F, 1'b1);
      do_req(K_BR, 5'd0, 5'd0, 5'd0, 6'd0, 3'd7, 32'h0000_0102);
      expect_err("br_align", 2'd2);
      idle(1);
      check("err_one_cycle", 64'(err_valid), 64'(0));

      // Memory access, illegal store+sx, out-of-range displacement.
      do_req(K_MEM, 5'd7, 5'd2, 5'd0, 6'b000010, 3'd0, 32'hFFFF_FFFC);
      expect_out("mem_ld", 32'hFFFC11E8, 1'b1);
      do_req(K_MEM, 5'd7, 5'd2, 5'd0, 6'b001110, 3'd0, 32'h0);
      expect_err("mem_st_sx", 2'd3);
      do_req(K_MEM, 5'd7, 5'd2, 5'd0, 6'b000010, 3'd0, 32'h0000_8000);
      expect_err("mem_range", 2'd1);
      idle(2);

      // Ten back-to-back address requests: one word per cycle.
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         do_req(K_ADR, 5'(i), 5'(i + 1), 5'd0, 6'd0, 3'd0, 32'(i * 4 - 20));
         check("adr_nobubble", 64'(out_valid), 64'(1));
      end
      check("adr_cycles", 64'(cyc - c0), 64'(10));
      idle(2);

      // Reset between the two K_LI words drops the second word.
      out_ready = 1'b0;
      do_req(K_LI, 5'd9, 5'd0, 5'd0, 6'd0, 3'd0, 32'hDEADBEEF);
      req_valid = 1'b0;
      expect_out("rst_w0", 32'hDEAD0058 | 32'(ALU_OR) | 32'h0000_0200, 1'b0);
      rst_n = 1'b0;
      #1;
      expect_reset("midreset");
      exp_w.delete();
      exp_e.delete();
      tick();
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      repeat (5) begin
         tick();
         check("rst_no_w1", 64'(out_valid), 64'(0));
      end

      // Randomized requests with random downstream backpressure.
      rand_ready = 1;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 65535));
            2: imm = {16'($urandom), 16'h0000};
            3: imm = 32'(int'($urandom_range(0, 65535)) - 32768);
            4: begin
               tmp = $urandom;
               imm = tmp[27] ? (tmp | 32'hF000_0000) : (tmp & 32'h0FFF_FFFF);
               if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            end
            default: imm = bnd[$urandom_range(0, 7)];
         endcase
         do_req(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom),
                6'($urandom), 3'($urandom), imm);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rand_ready = 0;
      out_ready  = 1'b1;
      idle(6);
      check("words_left", 64'(exp_w.size()), 64'(0));
      check("errs_left", 64'(exp_e.size()), 64'(0));
      check("word_count_final", 64'(word_count), 64'(16'(n_fire)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Hardware instruction encoder: accepts structured encode requests over a valid/ready handshake and emits the matching 32-bit br32 instruction words on a valid/ready output stream. It is the inverse of the instruction decoder. The debug unit uses it to build instruction sequences for the core's injection port. A 32-bit constant load expands to one or two words. Illegal requests are reported on an error strobe and produce no words.

## Interface
- (no parameters)
- `clk` in 1 — clock
- `rst_n` in 1 — asynchronous active-low reset
- `req_valid` in 1 / `req_ready` out 1 — request handshake
- `req_kind` in `enc_kind_t` (3) — one of `K_ALU_RR`, `K_ALU_RI`, `K_LI`, `K_MEM`, `K_ADR`, `K_BR`
- `req_rd`, `req_rs1`, `req_rs2` in 5 each — register fields; for stores, `req_rd` is the data register
- `req_opc` in 6 — ALU opcode. `K_ALU_RR` uses [5:0]; `K_ALU_RI` uses [2:0] plus [3] as the high-immediate flag. `K_MEM` uses [1:0] as size, [2] as store, [3] as sign-extend.
- `req_cond` in 3 — `K_BR` only: 0–5 conditional, 6 always, 7 call (link)
- `req_imm` in 32 — immediate or byte branch offset
- `out_valid` out 1 / `out_ready` in 1 — word stream handshake
- `out_instr` out 32 — encoded word
- `out_last` out 1 — final word of the current request
- `err_valid` out 1 — one-cycle error strobe
- `err_code` out 2 — 1 range, 2 alignment, 3 illegal combination
- `word_count` out 16 — count of words accepted downstream; wraps

## Operation
- Fields: `rd`=[10:6], `rs1`=[15:11], `rs2`=[20:16], `imm16`=[31:16].
- `K_ALU_RR`: [5:0]=0x3E, [31:21]={5'b0, opc}.
- `K_ALU_RI`: [5:4]=1, [3]=high flag, [2:0]=opc. Requires `req_imm[31:16]`==0, else range error.
- `K_LI` (rd, imm32), always uses `ALU_OR` with rs1=r0. This form is checked before the next one:
  - If imm[31:16]==0, emit one word: low form, imm16=imm[15:0].
  - Else if imm[15:0]==0, emit one word: high form, imm16=imm[31:16].
  - Otherwise emit two words: high form rd←r0|imm[31:16], then low form rd←rd|imm[15:0].
- `K_MEM`: [5:4]=2, [3:2]=size, [1]=store, [0]=sx.
  - imm must fit signed 16 bits, else range error.
  - store with sx=1 is an illegal-combination error.
- `K_ADR`: [5:0]=0x34, rs1 field 0, imm must fit signed 16 bits.
- `K_BR`: [5:3]=3'b001, [2:0]=cond, [31:6]=off[27:2].
  - off[1:0]≠0 is an alignment error.
  - off[31:28] not all equal to off[27] is a range error.
- Error precedence: illegal combination, then alignment, then range.
- FSM states:
  - `IDLE`: output register empty or draining.
  - `HOLD`: word in output register.
  - `SECOND`: second `K_LI` word pending.
- `req_ready` = !`pending_second` && (!`out_valid` || `out_ready`).
- Errored requests are accepted and consumed but emit nothing.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_last`=0, `err_valid`=0, `err_code`=0, `word_count`=0, `req_ready`=1. The FSM resets to `IDLE`.
- All outputs are registered. Latency from accepted request to `out_valid` (or `err_valid`) is 1 cycle.
- Throughput is one word per cycle while `out_ready` stays high, including back-to-back single-word requests.
- Two-word `K_LI`:
  - word 0 has `out_last`=0; `req_ready` is low until word 0 is accepted.
  - word 1 is presented the cycle after the word 0 handshake, with `out_last`=1.
- `out_instr`/`out_last` hold stable while `out_valid` && !`out_ready`.
- `word_count` increments on each `out_valid`&&`out_ready` and wraps 0xFFFF→0.
- An asserted reset mid-sequence drops any pending second word; nothing resumes after release.

## Structure
- `decoder_pkg` gains:
  - `enc_kind_t`
  - `ALU_OR`
  - field-position localparams shared with the decoder
  - `enc_err_t`
- Sub-module `instr_pack`: combinational. Takes the request and a word index (0/1). Returns the word, word count (1/2), error and error code.
- The top level holds the FSM, output register and counter.

## Test plan
- `K_ALU_RR` rd=3, rs1=4, rs2=5, opc=0x12, `out_ready`=1 → `out_instr`=0x024520FE one cycle later, `out_last`=1.
- `K_LI` rd=1, imm=0x12345678 with `out_ready` low for 3 cycles:
  - word0=0x12340058|`ALU_OR` stays stable, `req_ready`=0;
  - then word1=0x56780850|`ALU_OR` with `out_last`=1;
  - `word_count`=2.
- `K_BR` cond=2, off=−8 → 0xFFFFFF8A. Cond=7, off=0x100 → 0x0000100F. Off=0x102 → no word, `err_valid` pulse, `err_code`=2.
- `K_MEM` load, size 2, sx=0, rd=7, rs1=2, imm=−4 → 0xFFFC11E8. Store with sx=1 → `err_code`=3. Imm=0x8000 → `err_code`=1.
- Ten back-to-back `K_ADR` requests with `out_ready`=1 → ten consecutive words, no bubbles. Assert `rst_n` low between `K_LI` word0 and word1 → word1 is never emitted and all outputs return to reset values.
